// File: rtl/cfo_scale_pkg.sv
// Shared types and defaults for the CFO-path iterative scaler.
package cfo_scale_pkg;

  localparam int unsigned DW_DEFAULT  = 24;
  localparam int unsigned SHW_DEFAULT = 5;
  localparam int unsigned ID_W        = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/halve_rtz.sv
// One-step signed halving that rounds toward zero; cannot overflow.
module halve_rtz #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] adj;

  // Negative values get +1 before the arithmetic shift so odd results round up toward zero.
  always_comb begin
    adj = x_i + {{(W-1){1'b0}}, x_i[W-1]};
    y_o = {adj[W-1], adj[W-1:1]};
  end

endmodule

// File: rtl/cfo_scale_sched.sv
// Round-robin shared scaler: divides a granted sample by 2^k, one halving per cycle.
module cfo_scale_sched
  import cfo_scale_pkg::*;
#(
  parameter int unsigned DW  = DW_DEFAULT,
  parameter int unsigned SHW = SHW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [DW-1:0]  din_0,
  input  logic [DW-1:0]  din_1,
  input  logic [SHW-1:0] shift_0,
  input  logic [SHW-1:0] shift_1,
  output logic [1:0]     ack,
  output logic           busy,
  output logic [DW-1:0]  dout,
  output logic           dout_valid,
  output logic [ID_W-1:0] dout_id
);

  state_e         state_q, state_d;
  logic [DW-1:0]  x_q, x_d, x_half;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic           last_q, last_d;
  logic [1:0]     ack_q, ack_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           valid_q, valid_d;
  logic [ID_W-1:0] dout_id_q, dout_id_d;
  logic           win;

  halve_rtz #(
    .W (DW)
  ) u_halve (
    .x_i (x_q),
    .y_o (x_half)
  );

  // State and datapath registers with synchronous reset; last grant resets to 1 so 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      last_q    <= 1'b1;
      ack_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      dout_id_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      dout_id_q <= dout_id_d;
    end
  end

  // Next-state: round-robin accept in IDLE, one halving per RUN cycle, emit when count hits zero.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    ack_d     = 2'b00;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    dout_id_d = dout_id_q;
    // On contention the requester that did not win last time goes next.
    win       = (req == 2'b11) ? ~last_q : req[1];
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          x_d     = win ? din_1 : din_0;
          cnt_d   = win ? shift_1 : shift_0;
          id_d    = ID_W'(win);
          last_d  = win;
          ack_d   = win ? 2'b10 : 2'b01;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          x_d   = x_half;
          cnt_d = cnt_q - SHW'(1);
        end else begin
          dout_d    = x_q;
          dout_id_d = id_q;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  // Outputs come straight from registers; busy marks a job in flight.
  always_comb begin
    busy       = (state_q == RUN);
    ack        = ack_q;
    dout       = dout_q;
    dout_valid = valid_q;
    dout_id    = dout_id_q;
  end

endmodule
